// File: rtl/uart_arb_pkg.sv
// Shared types and default widths for the uart_core write-port arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    localparam int unsigned UART_ADDR_W = 4;
    localparam int unsigned UART_DATA_W = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i,
// wrapping from N_REQ-1 back to 0. Outputs a one-hot grant and its index.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o
);

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        logic          found;
        int unsigned   cand;
        logic [PW-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = PW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_write_arbiter.sv
// Shares the uart_core Avalon-MM write port among N_REQ requesters:
// round-robin selection, burst locking via req_last_i, and a fixed idle gap
// after every accepted write. Beats are registered before reaching avm_*.
module uart_write_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_W     = UART_ADDR_W,
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    input  logic [N_REQ-1:0]           req_last_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o,
    output logic [ADDR_W-1:0]          avm_address_o,
    output logic                       avm_write_o,
    output logic [DATA_W-1:0]          avm_writedata_o,
    input  logic                       avm_ready_i
);

    localparam int unsigned      PW       = $clog2(N_REQ);
    localparam int unsigned      GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]    GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [PW-1:0]    LAST_IDX = PW'(N_REQ - 1);

    arb_state_t          state_q,  state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       owner_q,  owner_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                last_q,   last_d;
    logic [GW-1:0]       gap_q,    gap_d;
    logic [N_REQ-1:0]    grant_q,  grant_d;
    logic                busy_q,   busy_d;
    logic                gap_done;

    logic [N_REQ-1:0]    pick_gnt;
    logic [PW-1:0]       pick_idx;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Next-state, hold-register load and handshake/write strobes.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_d      = last_q;
        gap_d       = gap_q;
        gap_done    = 1'b0;
        req_ready_o = '0;
        avm_write_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o = pick_gnt;
                    owner_d     = pick_idx;
                    addr_d      = req_addr_i[32'(pick_idx)*ADDR_W +: ADDR_W];
                    data_d      = req_data_i[32'(pick_idx)*DATA_W +: DATA_W];
                    last_d      = req_last_i[pick_idx];
                    state_d     = WRITE;
                end
            end
            HOLD: begin
                req_ready_o[owner_q] = req_valid_i[owner_q];
                if (req_valid_i[owner_q]) begin
                    addr_d  = req_addr_i[32'(owner_q)*ADDR_W +: ADDR_W];
                    data_d  = req_data_i[32'(owner_q)*DATA_W +: DATA_W];
                    last_d  = req_last_i[owner_q];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                avm_write_o = 1'b1;
                if (avm_ready_i) begin
                    if (GAP_CYCLES == 0) begin
                        gap_done = 1'b1;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    gap_done = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared exit for GAP expiry and a zero-length gap straight from WRITE.
        if (gap_done) begin
            if (last_q) begin
                rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
                state_d  = IDLE;
            end else begin
                state_d = HOLD;
            end
        end

        busy_d  = (state_d != IDLE);
        grant_d = '0;
        if (busy_d) begin
            grant_d[owner_d] = 1'b1;
        end
    end

    // State, pointer, hold registers and registered status outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            gap_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign grant_o         = grant_q;
    assign busy_o          = busy_q;
    assign avm_address_o   = addr_q;
    assign avm_writedata_o = data_q;

endmodule

// File: tb/tb_uart_write_arbiter.sv
// Directed bench for uart_write_arbiter: one instance with a 4-cycle gap and
// one with no gap, exercised by a linear sequence of hand-checked steps.
module tb_uart_write_arbiter;

    logic        clk = 1'b0;
    logic        arst;

    logic [3:0]  valid, last, ready, grant;
    logic [15:0] addr;
    logic [31:0] data;
    logic        busy, awrite, aready;
    logic [3:0]  aaddr;
    logic [7:0]  adata;

    logic [3:0]  validz, lastz, readyz, grantz;
    logic [15:0] addrz;
    logic [31:0] dataz;
    logic        busyz, awritez, areadyz;
    logic [3:0]  aaddrz;
    logic [7:0]  adataz;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] acc_d[$];
    logic [3:0] acc_a[$];
    int         acc_c[$];
    logic [7:0] accz_d[$];
    int         accz_c[$];

    uart_write_arbiter #(
        .N_REQ      (4),
        .ADDR_W     (4),
        .DATA_W     (8),
        .GAP_CYCLES (4)
    ) dut (
        .clk_i           (clk),
        .arst_i          (arst),
        .req_valid_i     (valid),
        .req_addr_i      (addr),
        .req_data_i      (data),
        .req_last_i      (last),
        .req_ready_o     (ready),
        .grant_o         (grant),
        .busy_o          (busy),
        .avm_address_o   (aaddr),
        .avm_write_o     (awrite),
        .avm_writedata_o (adata),
        .avm_ready_i     (aready)
    );

    uart_write_arbiter #(
        .N_REQ      (4),
        .ADDR_W     (4),
        .DATA_W     (8),
        .GAP_CYCLES (0)
    ) dutz (
        .clk_i           (clk),
        .arst_i          (arst),
        .req_valid_i     (validz),
        .req_addr_i      (addrz),
        .req_data_i      (dataz),
        .req_last_i      (lastz),
        .req_ready_o     (readyz),
        .grant_o         (grantz),
        .busy_o          (busyz),
        .avm_address_o   (aaddrz),
        .avm_write_o     (awritez),
        .avm_writedata_o (adataz),
        .avm_ready_i     (areadyz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [3:0] a,
                           input logic [7:0] d, input logic l);
        valid[k]         = v;
        addr[k*4 +: 4]   = a;
        data[k*8 +: 8]   = d;
        last[k]          = l;
    endtask

    task automatic set_reqz(input int k, input logic v, input logic [3:0] a,
                            input logic [7:0] d, input logic l);
        validz[k]        = v;
        addrz[k*4 +: 4]  = a;
        dataz[k*8 +: 8]  = d;
        lastz[k]         = l;
    endtask

    // Record accepted writes just before the edge, then land 1 time unit after it.
    task automatic tick();
        @(negedge clk);
        if (awrite && aready) begin
            acc_d.push_back(adata);
            acc_a.push_back(aaddr);
            acc_c.push_back(cyc);
        end
        if (awritez && areadyz) begin
            accz_d.push_back(adataz);
            accz_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        acc_d.delete();
        acc_a.delete();
        acc_c.delete();
        accz_d.delete();
        accz_c.delete();
    endtask

    task automatic do_reset();
        valid  = '0; last  = '0; addr  = '0; data  = '0;
        validz = '0; lastz = '0; addrz = '0; dataz = '0;
        arst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        arst = 1'b0;
        @(posedge clk);
        #1;
        clear_q();
        cyc = 0;
    endtask

    initial begin
        logic [7:0] burst[3];
        logic [7:0] exp4[4];
        int         idx1;
        logic       got0;
        int         pause;
        logic       multi;
        logic       stable;

        burst = '{8'h13, 8'h19, 8'h21};
        exp4  = '{8'h13, 8'h19, 8'h21, 8'h66};

        valid  = '0; last  = '0; addr  = '0; data  = '0;
        validz = '0; lastz = '0; addrz = '0; dataz = '0;
        aready = 1'b0;
        areadyz = 1'b1;
        arst   = 1'b1;
        #2;
        chk("rst_ready",  ready,  4'b0000);
        chk("rst_grant",  grant,  4'b0000);
        chk("rst_busy",   busy,   1'b0);
        chk("rst_awrite", awrite, 1'b0);
        chk("rst_aaddr",  aaddr,  4'h0);
        chk("rst_adata",  adata,  8'h00);

        // Single beat from requester 2
        do_reset();
        aready = 1'b1;
        set_req(2, 1'b1, 4'h1, 8'h13, 1'b1);
        #1;
        chk("t1_ready_idle", ready, 4'b0100);
        chk("t1_grant_pre",  grant, 4'b0000);
        tick();
        set_req(2, 1'b0, 4'h0, 8'h00, 1'b0);
        chk("t1_awrite", awrite, 1'b1);
        chk("t1_aaddr",  aaddr,  4'h1);
        chk("t1_adata",  adata,  8'h13);
        chk("t1_grant",  grant,  4'b0100);
        chk("t1_busy",   busy,   1'b1);
        chk("t1_ready_w", ready, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t1_gap%0d", i), {awrite, busy}, 2'b01);
        end
        tick();
        chk("t1_idle_busy",  busy,  1'b0);
        chk("t1_idle_grant", grant, 4'b0000);
        chk("t1_accepts", acc_d.size(), 1);
        set_req(0, 1'b1, 4'h0, 8'h00, 1'b1);
        set_req(3, 1'b1, 4'h0, 8'h00, 1'b1);
        #1;
        chk("t1_rrptr3", ready, 4'b1000);
        set_req(0, 1'b0, 4'h0, 8'h00, 1'b0);
        set_req(3, 1'b0, 4'h0, 8'h00, 1'b0);

        // All four requesters valid from reset
        do_reset();
        aready = 1'b1;
        multi  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(k, 1'b1, 4'(k), 8'hA0 + 8'(k), 1'b1);
        end
        for (int i = 0; i < 80 && acc_d.size() < 5; i++) begin
            #1;
            if ($countones(ready) > 1) multi = 1'b1;
            tick();
        end
        valid = '0;
        chk("t2_count", acc_d.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_data%0d", i), (i < acc_d.size()) ? acc_d[i] : 8'hxx,
                8'hA0 + 8'(i % 4));
        end
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t2_period%0d", i),
                (i < acc_c.size()) ? acc_c[i] - acc_c[i-1] : -1, 6);
        end
        chk("t2_ready_onehot", multi, 1'b0);

        // Locked burst from requester 1 while requester 0 waits
        do_reset();
        aready = 1'b1;
        set_req(0, 1'b1, 4'hC, 8'h55, 1'b1);
        tick();
        set_req(0, 1'b0, 4'h0, 8'h00, 1'b0);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("t3_pre_idle", busy, 1'b0);
        clear_q();
        idx1  = 0;
        got0  = 1'b0;
        pause = 0;
        for (int i = 0; i < 120 && acc_d.size() < 4; i++) begin
            set_req(1, (idx1 < 3) && !(idx1 == 1 && pause < 10), 4'h2,
                    (idx1 < 3) ? burst[idx1] : 8'h00, idx1 == 2);
            set_req(0, !got0, 4'hC, 8'h66, 1'b1);
            #1;
            if (ready[1] && valid[1]) idx1++;
            if (ready[0] && valid[0]) got0 = 1'b1;
            if (idx1 == 1) pause++;
            tick();
        end
        valid = '0;
        chk("t3_count", acc_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_data%0d", i), (i < acc_d.size()) ? acc_d[i] : 8'hxx, exp4[i]);
        end
        chk("t3_addr_first", (acc_a.size() > 0) ? acc_a[0] : 4'hx, 4'h2);
        chk("t3_addr_last",  (acc_a.size() > 3) ? acc_a[3] : 4'hx, 4'hC);

        // Back-pressure: 20 stalled cycles in WRITE
        do_reset();
        aready = 1'b0;
        set_req(3, 1'b1, 4'h7, 8'h5A, 1'b1);
        #1;
        chk("t4_ready", ready, 4'b1000);
        tick();
        set_req(3, 1'b0, 4'hF, 8'hFF, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(awrite && aaddr == 4'h7 && adata == 8'h5A && ready == 4'b0000)) stable = 1'b0;
            tick();
        end
        chk("t4_stable", stable, 1'b1);
        chk("t4_none_yet", acc_d.size(), 0);
        aready = 1'b1;
        repeat (10) tick();
        chk("t4_one_accept", acc_d.size(), 1);
        chk("t4_acc_data", (acc_d.size() > 0) ? acc_d[0] : 8'hxx, 8'h5A);
        chk("t4_acc_addr", (acc_a.size() > 0) ? acc_a[0] : 4'hx, 4'h7);

        // No-gap instance: requester 3 streaming, then pointer wrap check
        do_reset();
        set_reqz(3, 1'b1, 4'h3, 8'h3C, 1'b1);
        for (int i = 0; i < 40 && accz_d.size() < 4; i++) tick();
        chk("t5_count", accz_d.size(), 4);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t5_period%0d", i),
                (i < accz_c.size()) ? accz_c[i] - accz_c[i-1] : -1, 2);
        end
        set_reqz(2, 1'b1, 4'h2, 8'h2C, 1'b1);
        for (int i = 0; i < 40 && accz_d.size() < 6; i++) tick();
        validz = '0;
        chk("t5_wrap_req2", (accz_d.size() > 4) ? accz_d[4] : 8'hxx, 8'h2C);
        chk("t5_then_req3", (accz_d.size() > 5) ? accz_d[5] : 8'hxx, 8'h3C);

        // Reset asserted mid-WRITE
        do_reset();
        aready = 1'b0;
        set_req(2, 1'b1, 4'h5, 8'h77, 1'b1);
        tick();
        set_req(2, 1'b0, 4'h0, 8'h00, 1'b0);
        chk("t6_in_write", awrite, 1'b1);
        #2;
        arst = 1'b1;
        #1;
        chk("t6_awrite", awrite, 1'b0);
        chk("t6_aaddr",  aaddr,  4'h0);
        chk("t6_adata",  adata,  8'h00);
        chk("t6_busy",   busy,   1'b0);
        chk("t6_grant",  grant,  4'b0000);
        chk("t6_ready",  ready,  4'b0000);
        @(posedge clk);
        #3;
        arst = 1'b0;
        aready = 1'b1;
        clear_q();
        repeat (5) tick();
        chk("t6_no_retry", acc_d.size(), 0);
        valid = 4'b1111;
        #1;
        chk("t6_first_grant", ready, 4'b0001);
        valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
